// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the iterative FP units: operand classes,
// rounding-mode encoding, exception-flag bundle and format-derived constants.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO   = 2'd0,
    FP_NORMAL = 2'd1,
    FP_INF    = 2'd2,
    FP_NAN    = 2'd3
  } fp_class_t;

  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

  typedef struct packed {
    logic invalid;
    logic div_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  function automatic int fp_bias(input int exp_width);
    return (1 << (exp_width - 1)) - 1;
  endfunction

  function automatic int fp_exp_max(input int exp_width);
    return (1 << exp_width) - 1;
  endfunction

  // Subnormals classify as zero: the datapath flushes them.
  function automatic fp_class_t fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_nz);
    if (exp_zero) return FP_ZERO;
    if (exp_ones) return frac_nz ? FP_NAN : FP_INF;
    return FP_NORMAL;
  endfunction

endpackage

// File: rtl/fp_div_iter_if.sv
// Operand/result handshake bundle for the iterative FP divider.
interface fp_div_iter_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
);
  localparam int W = 1 + EXP_WIDTH + FRAC_WIDTH;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         rnd_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_invalid;
  logic         flag_div_zero;
  logic         flag_overflow;
  logic         flag_underflow;
  logic         flag_inexact;

  modport master (
    output in_valid, op_a, op_b, rnd_mode, out_ready,
    input  in_ready, out_valid, result,
           flag_invalid, flag_div_zero, flag_overflow, flag_underflow, flag_inexact
  );

  modport slave (
    input  in_valid, op_a, op_b, rnd_mode, out_ready,
    output in_ready, out_valid, result,
           flag_invalid, flag_div_zero, flag_overflow, flag_underflow, flag_inexact
  );
endinterface

// File: rtl/fp_round_pack.sv
// Combinational normalise/round/pack: takes a raw quotient with hidden bit at the
// MSB or one below it, applies RNE/RTZ and resolves overflow/underflow into the result.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter  int EXP_WIDTH  = 8,
  parameter  int FRAC_WIDTH = 23,
  localparam int Q          = FRAC_WIDTH + 3,
  localparam int XW         = EXP_WIDTH + 2
) (
  input  logic                            sign,
  input  logic                            rnd_mode,
  input  logic [Q-1:0]                    quo,
  input  logic                            rem_nz,
  input  logic signed [XW-1:0]            exp_in,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]   result,
  output fp_flags_t                       flags
);
  localparam logic signed [XW-1:0] EXP_ONES = XW'(fp_exp_max(EXP_WIDTH));
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  logic                    shift;
  logic                    guard;
  logic                    sticky;
  logic                    inc;
  logic [FRAC_WIDTH-1:0]   frac_pre;
  logic [FRAC_WIDTH:0]     frac_sum;
  logic signed [XW-1:0]    exp_r;

  always_comb begin
    // Quotient of two [1,2) mantissas lies in (0.5,2): at most one left shift.
    shift    = ~quo[Q-1];
    frac_pre = shift ? quo[FRAC_WIDTH:1] : quo[FRAC_WIDTH+1:2];
    guard    = shift ? quo[0] : quo[1];
    sticky   = rem_nz | (~shift & quo[0]);
    inc      = (rnd_mode == RND_RNE) & guard & (sticky | frac_pre[0]);
    frac_sum = {1'b0, frac_pre} + {{FRAC_WIDTH{1'b0}}, inc};
    exp_r    = exp_in - {{(XW-1){1'b0}}, shift} + {{(XW-1){1'b0}}, frac_sum[FRAC_WIDTH]};

    flags         = '0;
    flags.inexact = guard | sticky;
    result        = {sign, exp_r[EXP_WIDTH-1:0], frac_sum[FRAC_WIDTH-1:0]};

    if (exp_r >= EXP_ONES) begin
      flags.overflow = 1'b1;
      flags.inexact  = 1'b1;
      if (rnd_mode == RND_RTZ)
        result = {sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {FRAC_WIDTH{1'b1}}};
      else
        result = {sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
    end else if (exp_r <= EXP_ZERO) begin
      flags.underflow = 1'b1;
      flags.inexact   = 1'b1;
      result          = {sign, {(EXP_WIDTH+FRAC_WIDTH){1'b0}}};
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider, one quotient bit per cycle, one operation in flight.
// Special operands resolve at capture and are presented the next cycle.
module fp_div_iter
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23
) (
  input logic          clk,
  input logic          rst,
  fp_div_iter_if.slave bus
);
  localparam int W  = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int Q  = FRAC_WIDTH + 3;
  localparam int CW = $clog2(Q + 1);
  localparam int XW = EXP_WIDTH + 2;

  localparam logic signed [XW-1:0] BIAS_X    = XW'(fp_bias(EXP_WIDTH));
  localparam logic [CW-1:0]        LAST_ITER = CW'(Q - 1);
  localparam logic [W-1:0]         QNAN      = {1'b1, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ITER  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FRAC_WIDTH+1:0]  rem_q, rem_d;
  logic [FRAC_WIDTH:0]    div_q, div_d;
  logic [Q-1:0]           quo_q, quo_d;
  logic                   sign_q, sign_d;
  logic                   rnd_q, rnd_d;
  logic signed [XW-1:0]   exp_q, exp_d;
  logic [W-1:0]           result_q, result_d;
  fp_flags_t              flags_q, flags_d;

  logic                   sa, sb;
  logic [EXP_WIDTH-1:0]   ea, eb;
  logic [FRAC_WIDTH-1:0]  fa, fb;
  fp_class_t              cls_a, cls_b;
  logic                   rem_ge;
  logic [FRAC_WIDTH+1:0]  rem_sub;
  logic [W-1:0]           rp_result;
  fp_flags_t              rp_flags;

  assign {sa, ea, fa} = bus.op_a;
  assign {sb, eb, fb} = bus.op_b;
  assign cls_a   = fp_classify(ea == '0, &ea, |fa);
  assign cls_b   = fp_classify(eb == '0, &eb, |fb);
  assign rem_ge  = rem_q >= {1'b0, div_q};
  assign rem_sub = rem_q - {1'b0, div_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    sign_d   = sign_q;
    rnd_d    = rnd_q;
    exp_d    = exp_q;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      S_IDLE: if (bus.in_valid) begin
        sign_d  = sa ^ sb;
        rnd_d   = bus.rnd_mode;
        flags_d = '0;
        state_d = S_HOLD;
        if (cls_a == FP_NAN || cls_b == FP_NAN ||
            (cls_a == FP_ZERO && cls_b == FP_ZERO) ||
            (cls_a == FP_INF  && cls_b == FP_INF)) begin
          result_d         = QNAN;
          flags_d.invalid  = 1'b1;
        end else if (cls_b == FP_ZERO) begin
          result_d         = {sa ^ sb, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
          flags_d.div_zero = (cls_a == FP_NORMAL);
        end else if (cls_a == FP_INF) begin
          result_d         = {sa ^ sb, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
        end else if (cls_b == FP_INF || cls_a == FP_ZERO) begin
          result_d         = {sa ^ sb, {(EXP_WIDTH+FRAC_WIDTH){1'b0}}};
        end else begin
          rem_d   = {2'b01, fa};
          div_d   = {1'b1, fb};
          quo_d   = '0;
          cnt_d   = '0;
          exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_X;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        quo_d = {quo_q[Q-2:0], rem_ge};
        rem_d = (rem_ge ? rem_sub : rem_q) << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d = rp_result;
        flags_d  = rp_flags;
        state_d  = S_HOLD;
      end
      default: if (bus.out_ready) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      sign_q   <= 1'b0;
      rnd_q    <= 1'b0;
      exp_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      sign_q   <= sign_d;
      rnd_q    <= rnd_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  fp_round_pack #(
    .EXP_WIDTH  (EXP_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_round_pack (
    .sign     (sign_q),
    .rnd_mode (rnd_q),
    .quo      (quo_q),
    .rem_nz   (|rem_q),
    .exp_in   (exp_q),
    .result   (rp_result),
    .flags    (rp_flags)
  );

  assign bus.in_ready       = (state_q == S_IDLE);
  assign bus.out_valid      = (state_q == S_HOLD);
  assign bus.result         = result_q;
  assign bus.flag_invalid   = flags_q.invalid;
  assign bus.flag_div_zero  = flags_q.div_zero;
  assign bus.flag_overflow  = flags_q.overflow;
  assign bus.flag_underflow = flags_q.underflow;
  assign bus.flag_inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter: directed vectors, backpressure, reset abort, random binary32
// against an exact-integer reference divider, and a binary64 instance.
module tb_fp_div_iter;

  logic clk;
  logic rst;

  fp_div_iter_if #(.EXP_WIDTH(8),  .FRAC_WIDTH(23)) if32 ();
  fp_div_iter_if #(.EXP_WIDTH(11), .FRAC_WIDTH(52)) if64 ();

  fp_div_iter #(.EXP_WIDTH(8),  .FRAC_WIDTH(23)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  fp_div_iter #(.EXP_WIDTH(11), .FRAC_WIDTH(52)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;   // {invalid, div_zero, overflow, underflow, inexact}
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        rtz;
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  // Reference: exact integer quotient of the significands, rounded from the true remainder.
  function automatic exp_t ref_div32(input logic [31:0] a, input logic [31:0] b, input logic rtz);
    exp_t   r;
    logic   s;
    int     ea, eb, e;
    longint ma, mb, n, q, rm;
    bit     a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, inexact;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    s = a[31] ^ b[31];
    r.lat = 1;
    r.fl  = 5'b00000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      r.res = 32'hFFC00000;
      r.fl  = 5'b10000;
      return r;
    end
    if (b_zero) begin
      r.res = {s, 8'hFF, 23'd0};
      r.fl  = a_inf ? 5'b00000 : 5'b01000;
      return r;
    end
    if (a_inf) begin
      r.res = {s, 8'hFF, 23'd0};
      return r;
    end
    if (b_inf || a_zero) begin
      r.res = {s, 31'd0};
      return r;
    end
    r.lat = 28;
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    e  = ea - eb + 127;
    if (ma >= mb) n = ma << 23;
    else begin
      n = ma << 24;
      e = e - 1;
    end
    q  = n / mb;
    rm = n % mb;
    inexact = (rm != 0);
    if (!rtz && ((2 * rm > mb) || ((2 * rm == mb) && q[0]))) q = q + 1;
    if (q == (longint'(1) << 24)) begin
      q = longint'(1) << 23;
      e = e + 1;
    end
    if (e >= 255) begin
      r.res = rtz ? {s, 31'h7F7FFFFF} : {s, 31'h7F800000};
      r.fl  = 5'b00101;
    end else if (e <= 0) begin
      r.res = {s, 31'd0};
      r.fl  = 5'b00011;
    end else begin
      r.res = {s, 8'(e), q[22:0]};
      r.fl  = {4'b0000, inexact};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_fp32();
    logic [7:0]  e;
    logic [22:0] f;
    int          k;
    k = int'($urandom_range(0, 11));
    f = 23'($urandom);
    case (k)
      0: e = 8'd0;
      1: begin e = 8'hFF; f = '0; end
      2: begin e = 8'hFF; f = f | 23'd1; end
      3: e = 8'($urandom_range(1, 20));
      4: e = 8'($urandom_range(235, 254));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, f};
  endfunction

  task automatic set_in(input bit wide, input logic vld, input logic [63:0] a,
                        input logic [63:0] b, input logic rtz);
    if (wide) begin
      if64.in_valid = vld;
      if64.op_a     = a;
      if64.op_b     = b;
      if64.rnd_mode = rtz;
    end else begin
      if32.in_valid = vld;
      if32.op_a     = a[31:0];
      if32.op_b     = b[31:0];
      if32.rnd_mode = rtz;
    end
  endtask

  function automatic logic out_vld(input bit wide);
    return wide ? if64.out_valid : if32.out_valid;
  endfunction

  function automatic logic [63:0] get_res(input bit wide);
    return wide ? if64.result : {32'd0, if32.result};
  endfunction

  function automatic logic [4:0] get_fl(input bit wide);
    if (wide)
      return {if64.flag_invalid, if64.flag_div_zero, if64.flag_overflow,
              if64.flag_underflow, if64.flag_inexact};
    return {if32.flag_invalid, if32.flag_div_zero, if32.flag_overflow,
            if32.flag_underflow, if32.flag_inexact};
  endfunction

  // Issues one operation from an idle DUT; lat counts the accepting edge as cycle 1.
  task automatic run_op(input bit wide, input logic [63:0] a, input logic [63:0] b,
                        input logic rtz, input int stall, output logic [63:0] res,
                        output logic [4:0] fl, output int lat);
    if (wide) if64.out_ready = (stall == 0);
    else      if32.out_ready = (stall == 0);
    set_in(wide, 1'b1, a, b, rtz);
    @(posedge clk); #1;
    set_in(wide, 1'b0, a, b, rtz);
    lat = 1;
    while (!out_vld(wide) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_eq("out_valid_seen", out_vld(wide), 1);
    res = get_res(wide);
    fl  = get_fl(wide);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    if (wide) if64.out_ready = 1'b1;
    else      if32.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t        vq[$];
  logic [63:0] res;
  logic [4:0]  fl;
  int          lat;
  exp_t        m;
  logic [31:0] ra, rb;
  logic        rtz;
  bit          seen;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    set_in(1'b0, 1'b0, '0, '0, 1'b0);
    set_in(1'b1, 1'b0, '0, '0, 1'b0);
    if32.out_ready = 1'b1;
    if64.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk_eq("rst_out_valid", if32.out_valid, 0);
    chk_eq("rst_result",    if32.result, 0);
    chk_eq("rst_flags",     get_fl(1'b0), 0);
    chk_eq("rst_in_ready",  if32.in_ready, 1);
    chk_eq("rst_in_ready64", if64.in_ready, 1);

    vq.push_back('{32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAB, 5'b00001, 28});
    vq.push_back('{32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAA, 5'b00001, 28});
    vq.push_back('{32'h40C00000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000, 28});
    vq.push_back('{32'h3FC00000, 32'h3F800000, 1'b0, 32'h3FC00000, 5'b00000, 28});
    vq.push_back('{32'h3F800000, 32'h00000000, 1'b0, 32'h7F800000, 5'b01000, 1});
    vq.push_back('{32'h00000000, 32'h00000000, 1'b0, 32'hFFC00000, 5'b10000, 1});
    vq.push_back('{32'hFF800000, 32'h7F800000, 1'b0, 32'hFFC00000, 5'b10000, 1});
    vq.push_back('{32'h7F7FFFFF, 32'h3F000000, 1'b0, 32'h7F800000, 5'b00101, 28});
    vq.push_back('{32'h7F7FFFFF, 32'h3F000000, 1'b1, 32'h7F7FFFFF, 5'b00101, 28});
    vq.push_back('{32'h00800000, 32'h40000000, 1'b0, 32'h00000000, 5'b00011, 28});
    vq.push_back('{32'h7FC00000, 32'h3F800000, 1'b0, 32'hFFC00000, 5'b10000, 1});
    vq.push_back('{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 5'b00000, 1});
    vq.push_back('{32'h40000000, 32'hFF800000, 1'b0, 32'h80000000, 5'b00000, 1});
    vq.push_back('{32'h80000000, 32'h40000000, 1'b0, 32'h80000000, 5'b00000, 1});
    vq.push_back('{32'h00000001, 32'h3F800000, 1'b0, 32'h00000000, 5'b00000, 1});
    vq.push_back('{32'hC0C00000, 32'h40000000, 1'b0, 32'hC0400000, 5'b00000, 28});

    foreach (vq[i]) begin
      run_op(1'b0, {32'd0, vq[i].a}, {32'd0, vq[i].b}, vq[i].rtz, 0, res, fl, lat);
      chk_eq($sformatf("dir%0d_result", i), res, {32'd0, vq[i].res});
      chk_eq($sformatf("dir%0d_flags", i), fl, vq[i].fl);
      chk_eq($sformatf("dir%0d_latency", i), lat, vq[i].lat);
    end

    // Backpressure: hold the result while a competing operand waits on in_valid.
    if32.out_ready = 1'b0;
    set_in(1'b0, 1'b1, 64'h3F800000, 64'h40400000, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b1, 64'h40C00000, 64'h40000000, 1'b0);
    lat = 1;
    while (!if32.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_eq("bp_valid", if32.out_valid, 1);
    chk_eq("bp_latency", lat, 28);
    repeat (10) begin
      @(posedge clk); #1;
      chk_eq("bp_hold_valid",  if32.out_valid, 1);
      chk_eq("bp_hold_result", if32.result, 32'h3EAAAAAB);
      chk_eq("bp_hold_flags",  get_fl(1'b0), 5'b00001);
      chk_eq("bp_in_ready",    if32.in_ready, 0);
    end
    if32.out_ready = 1'b1;
    @(posedge clk); #1;
    chk_eq("bp_release_ready", if32.in_ready, 1);
    chk_eq("bp_release_valid", if32.out_valid, 0);
    run_op(1'b0, 64'h40C00000, 64'h40000000, 1'b0, 0, res, fl, lat);
    chk_eq("b2b_result",  res, 64'h40400000);
    chk_eq("b2b_flags",   fl, 5'b00000);
    chk_eq("b2b_latency", lat, 28);

    // Reset partway through the iteration phase must abort the operation.
    set_in(1'b0, 1'b1, 64'h3F800000, 64'h40400000, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_eq("abort_in_ready",  if32.in_ready, 1);
    chk_eq("abort_out_valid", if32.out_valid, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (if32.out_valid) seen = 1'b1;
    end
    chk_eq("abort_no_result", seen, 0);

    for (int i = 0; i < 250; i++) begin
      ra  = rand_fp32();
      rb  = rand_fp32();
      rtz = 1'($urandom);
      m   = ref_div32(ra, rb, rtz);
      run_op(1'b0, {32'd0, ra}, {32'd0, rb}, rtz, int'($urandom_range(0, 2)), res, fl, lat);
      chk_eq($sformatf("rnd%0d_result %h/%h", i, ra, rb), res, {32'd0, m.res});
      chk_eq($sformatf("rnd%0d_flags", i), fl, m.fl);
      chk_eq($sformatf("rnd%0d_latency", i), lat, m.lat);
    end

    run_op(1'b1, 64'h3FF0000000000000, 64'h4008000000000000, 1'b0, 0, res, fl, lat);
    chk_eq("b64_third_result",  res, 64'h3FD5555555555555);
    chk_eq("b64_third_flags",   fl, 5'b00001);
    chk_eq("b64_third_latency", lat, 57);
    run_op(1'b1, 64'h4018000000000000, 64'h4000000000000000, 1'b0, 0, res, fl, lat);
    chk_eq("b64_exact_result",  res, 64'h4008000000000000);
    chk_eq("b64_exact_flags",   fl, 5'b00000);
    run_op(1'b1, 64'hBFF0000000000000, 64'h0000000000000000, 1'b0, 0, res, fl, lat);
    chk_eq("b64_divzero_result",  res, 64'hFFF0000000000000);
    chk_eq("b64_divzero_flags",   fl, 5'b01000);
    chk_eq("b64_divzero_latency", lat, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
